// File: rtl/tuner_pkg.sv
// Shared tuner defaults: spectrum geometry for the guitar/bass search range
// and the peak-scan state encoding.
package tuner_pkg;

  localparam int          INDEX_WIDTH_DEF = 11;
  localparam int          MAG_WIDTH_DEF   = 24;
  localparam logic [15:0] BIN_STEP_Q8_DEF = 16'd6104;
  localparam int          MIN_BIN_DEF     = 1;
  localparam int          MAX_BIN_DEF     = 60;

  typedef enum logic {
    IDLE = 1'b0,
    SCAN = 1'b1
  } scan_state_t;

endpackage

// File: rtl/bin_to_hz.sv
// Registered bin-index to integer-Hz conversion: (idx * step_q8_8) >> 8.
// The product is sized so that it can never overflow.
module bin_to_hz #(
  parameter int          INDEX_WIDTH = 11,
  parameter int          FREQ_WIDTH  = INDEX_WIDTH + 16,
  parameter logic [15:0] BIN_STEP_Q8 = 16'd6104
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   en,
  input  logic [INDEX_WIDTH-1:0] idx,
  output logic [FREQ_WIDTH-1:0]  freq
);

  localparam int PW = INDEX_WIDTH + 16;

  logic [PW-1:0] prod;

  assign prod = PW'(idx) * PW'(BIN_STEP_Q8);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      freq <= '0;
    end else if (en) begin
      freq <= FREQ_WIDTH'(prod >> 8);
    end
  end

endmodule

// File: rtl/spectral_peak_picker.sv
// Streams one magnitude spectrum per frame, picks the strongest in-window bin
// and reports it as a frequency word. Optional macro: PEAK_SMOOTH_EN.
module spectral_peak_picker
  import tuner_pkg::*;
#(
  parameter int                   INDEX_WIDTH = INDEX_WIDTH_DEF,
  parameter int                   MAG_WIDTH   = MAG_WIDTH_DEF,
  parameter int                   FREQ_WIDTH  = INDEX_WIDTH + 16,
  parameter logic [15:0]          BIN_STEP_Q8 = BIN_STEP_Q8_DEF,
  parameter int                   MIN_BIN     = MIN_BIN_DEF,
  parameter int                   MAX_BIN     = MAX_BIN_DEF,
  parameter logic [MAG_WIDTH-1:0] MAG_THRESH  = MAG_WIDTH'(4096)
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic [MAG_WIDTH-1:0]   mag_data,
  input  logic [INDEX_WIDTH-1:0] mag_index,
  input  logic                   mag_valid,
  input  logic                   mag_last,
  output logic [FREQ_WIDTH-1:0]  freq_out,
  output logic                   freq_valid,
  output logic                   freq_strobe,
  output logic [MAG_WIDTH-1:0]   peak_mag
);

  scan_state_t            state;
  logic [MAG_WIDTH-1:0]   best_mag;
  logic [INDEX_WIDTH-1:0] best_idx;
  logic                   hit;
  logic                   in_win, take;
  logic [MAG_WIDTH-1:0]   fin_mag;
  logic [INDEX_WIDTH-1:0] fin_idx;

  logic                   vld_p0, cap_hit_p0, qual_p0;
  logic [MAG_WIDTH-1:0]   cap_mag_p0;
  logic [INDEX_WIDTH-1:0] cap_idx_p0, idx_p0;

  logic                   vld_p1, qual_p1;
  logic [MAG_WIDTH-1:0]   mag_p1;
  logic [FREQ_WIDTH-1:0]  freq_p1;

  // Strict '>' keeps the earliest index on ties; the first in-window beat always loads.
  assign in_win  = mag_valid && (int'(mag_index) >= MIN_BIN) && (int'(mag_index) <= MAX_BIN);
  assign take    = in_win && (!hit || (mag_data > best_mag));
  assign fin_mag = take ? mag_data  : best_mag;
  assign fin_idx = take ? mag_index : best_idx;

  // Stage 0: scan, capture the frame's winner on the last beat
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      best_mag   <= '0;
      best_idx   <= '0;
      hit        <= 1'b0;
      vld_p0     <= 1'b0;
      cap_mag_p0 <= '0;
      cap_idx_p0 <= '0;
      cap_hit_p0 <= 1'b0;
    end else begin
      vld_p0 <= mag_valid && mag_last;
      if (mag_valid) begin
        if (mag_last) begin
          cap_mag_p0 <= fin_mag;
          cap_idx_p0 <= fin_idx;
          cap_hit_p0 <= hit || in_win;
          best_mag   <= '0;
          best_idx   <= '0;
          hit        <= 1'b0;
          state      <= IDLE;
        end else begin
          if (take) begin
            best_mag <= mag_data;
            best_idx <= mag_index;
          end
          hit   <= hit || in_win;
          state <= SCAN;
        end
      end
    end
  end

  assign qual_p0 = cap_hit_p0 && (cap_mag_p0 >= MAG_THRESH);

`ifdef PEAK_SMOOTH_EN
  logic [INDEX_WIDTH-1:0] prev_idx_p1;
  logic                   prev_qual_p1;
  logic [INDEX_WIDTH:0]   idx_sum;

  assign idx_sum = {1'b0, prev_idx_p1} + {1'b0, cap_idx_p0};
  assign idx_p0  = (qual_p0 && prev_qual_p1) ? idx_sum[INDEX_WIDTH:1] : cap_idx_p0;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      prev_idx_p1  <= '0;
      prev_qual_p1 <= 1'b0;
    end else if (vld_p0) begin
      prev_idx_p1  <= cap_idx_p0;
      prev_qual_p1 <= qual_p0;
    end
  end
`else
  assign idx_p0 = cap_idx_p0;
`endif

  // Stage 1: index to Hz, qualify bit and magnitude travel alongside
  bin_to_hz #(
    .INDEX_WIDTH (INDEX_WIDTH),
    .FREQ_WIDTH  (FREQ_WIDTH),
    .BIN_STEP_Q8 (BIN_STEP_Q8)
  ) u_bin_to_hz (
    .clk     (clk),
    .reset_n (reset_n),
    .en      (vld_p0),
    .idx     (idx_p0),
    .freq    (freq_p1)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      vld_p1  <= 1'b0;
      qual_p1 <= 1'b0;
      mag_p1  <= '0;
    end else begin
      vld_p1 <= vld_p0;
      if (vld_p0) begin
        qual_p1 <= qual_p0;
        mag_p1  <= cap_mag_p0;
      end
    end
  end

  // Stage 2: output registers; unqualified frames keep the last good word
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      freq_strobe <= 1'b0;
      freq_valid  <= 1'b0;
      freq_out    <= '0;
      peak_mag    <= '0;
    end else begin
      freq_strobe <= vld_p1;
      if (vld_p1) begin
        freq_valid <= qual_p1;
        if (qual_p1) begin
          freq_out <= freq_p1;
          peak_mag <= mag_p1;
        end
      end
    end
  end

endmodule

// File: tb/tb_spectral_peak_picker.sv
// Directed bench for spectral_peak_picker with hand-computed frequency words.
module tb_spectral_peak_picker;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [23:0] mag_data;
  logic [10:0] mag_index;
  logic        mag_valid;
  logic        mag_last;
  logic [26:0] freq_out;
  logic        freq_valid;
  logic        freq_strobe;
  logic [23:0] peak_mag;

  int passed = 0;
  int total  = 0;

  spectral_peak_picker dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .mag_data    (mag_data),
    .mag_index   (mag_index),
    .mag_valid   (mag_valid),
    .mag_last    (mag_last),
    .freq_out    (freq_out),
    .freq_valid  (freq_valid),
    .freq_strobe (freq_strobe),
    .peak_mag    (peak_mag)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Bins first..first+n-1 at level base, with up to two peaks (index -1 = none).
  task automatic send_frame(input int pk_a, input int mag_a, input int pk_b, input int mag_b,
                            input int base, input int first, input int n, input bit close);
    for (int i = 0; i < n; i++) begin
      mag_index = 11'(first + i);
      mag_data  = 24'(base);
      if (first + i == pk_a) mag_data = 24'(mag_a);
      if (first + i == pk_b) mag_data = 24'(mag_b);
      mag_valid = 1'b1;
      mag_last  = close && (i == n - 1);
      step();
    end
    mag_valid = 1'b0;
    mag_last  = 1'b0;
  endtask

  task automatic test_reset();
    reset_n = 1'b0; mag_valid = 1'b0; mag_last = 1'b0; mag_data = '0; mag_index = '0;
    repeat (3) step();
    total++; if (freq_out !== 27'd0) $display("FAIL reset_freq: got %0d want 0", freq_out); else passed++;
    total++; if (freq_valid !== 1'b0) $display("FAIL reset_valid: got %b want 0", freq_valid); else passed++;
    total++; if (freq_strobe !== 1'b0) $display("FAIL reset_strobe: got %b want 0", freq_strobe); else passed++;
    total++; if (peak_mag !== 24'd0) $display("FAIL reset_mag: got %0d want 0", peak_mag); else passed++;
    reset_n = 1'b1;
    step();
  endtask

  task automatic test_single_peak();
    send_frame(7, 10000, -1, 0, 100, 0, 64, 1'b1);
    step();
    total++; if (freq_strobe !== 1'b0) $display("FAIL peak_strobe_early: got %b want 0", freq_strobe); else passed++;
    step();
    total++; if (freq_strobe !== 1'b1) $display("FAIL peak_strobe: got %b want 1", freq_strobe); else passed++;
    total++; if (freq_valid !== 1'b1) $display("FAIL peak_valid: got %b want 1", freq_valid); else passed++;
    total++; if (freq_out !== 27'd166) $display("FAIL peak_freq: got %0d want 166", freq_out); else passed++;
    total++; if (peak_mag !== 24'd10000) $display("FAIL peak_mag: got %0d want 10000", peak_mag); else passed++;
    step();
    total++; if (freq_strobe !== 1'b0) $display("FAIL peak_strobe_width: got %b want 0", freq_strobe); else passed++;
    total++; if (freq_valid !== 1'b1) $display("FAIL peak_valid_level: got %b want 1", freq_valid); else passed++;
  endtask

  task automatic test_tie();
    send_frame(5, 8000, 9, 8000, 100, 0, 64, 1'b1);
    step(); step();
    total++; if (freq_strobe !== 1'b1) $display("FAIL tie_strobe: got %b want 1", freq_strobe); else passed++;
    total++; if (freq_out !== 27'd119) $display("FAIL tie_freq: got %0d want 119", freq_out); else passed++;
    total++; if (peak_mag !== 24'd8000) $display("FAIL tie_mag: got %0d want 8000", peak_mag); else passed++;
    step();
  endtask

  task automatic test_below_thresh();
    send_frame(10, 4095, -1, 0, 100, 0, 64, 1'b1);
    step(); step();
    total++; if (freq_strobe !== 1'b1) $display("FAIL low_strobe: got %b want 1", freq_strobe); else passed++;
    total++; if (freq_valid !== 1'b0) $display("FAIL low_valid: got %b want 0", freq_valid); else passed++;
    total++; if (freq_out !== 27'd119) $display("FAIL low_freq_hold: got %0d want 119", freq_out); else passed++;
    total++; if (peak_mag !== 24'd8000) $display("FAIL low_mag_hold: got %0d want 8000", peak_mag); else passed++;
    step();
  endtask

  task automatic test_thresh_edge();
    send_frame(20, 4096, -1, 0, 100, 0, 64, 1'b1);
    step(); step();
    total++; if (freq_valid !== 1'b1) $display("FAIL edge_valid: got %b want 1", freq_valid); else passed++;
    total++; if (freq_out !== 27'd476) $display("FAIL edge_freq: got %0d want 476", freq_out); else passed++;
    total++; if (peak_mag !== 24'd4096) $display("FAIL edge_mag: got %0d want 4096", peak_mag); else passed++;
    step();
  endtask

  task automatic test_window();
    send_frame(61, 60000, 60, 5000, 100, 0, 64, 1'b1);
    step(); step();
    total++; if (freq_out !== 27'd1430) $display("FAIL win_freq: got %0d want 1430", freq_out); else passed++;
    total++; if (peak_mag !== 24'd5000) $display("FAIL win_mag: got %0d want 5000", peak_mag); else passed++;
    step();
  endtask

  task automatic test_empty_window();
    int strobes;
    send_frame(-1, 0, -1, 0, 50000, 100, 4, 1'b1);
    step(); step();
    total++; if (freq_strobe !== 1'b1) $display("FAIL empty_strobe: got %b want 1", freq_strobe); else passed++;
    total++; if (freq_valid !== 1'b0) $display("FAIL empty_valid: got %b want 0", freq_valid); else passed++;
    total++; if (freq_out !== 27'd1430) $display("FAIL empty_freq_hold: got %0d want 1430", freq_out); else passed++;
    step();
    mag_last = 1'b1;
    step();
    mag_last = 1'b0;
    strobes = 0;
    for (int c = 0; c < 4; c++) begin
      step();
      if (freq_strobe) strobes++;
    end
    total++; if (strobes !== 0) $display("FAIL lone_last_strobes: got %0d want 0", strobes); else passed++;
  endtask

  task automatic test_single_beat();
    send_frame(1, 9000, -1, 0, 0, 1, 1, 1'b1);
    step(); step();
    total++; if (freq_strobe !== 1'b1) $display("FAIL beat_strobe: got %b want 1", freq_strobe); else passed++;
    total++; if (freq_valid !== 1'b1) $display("FAIL beat_valid: got %b want 1", freq_valid); else passed++;
    total++; if (freq_out !== 27'd23) $display("FAIL beat_freq: got %0d want 23", freq_out); else passed++;
    total++; if (peak_mag !== 24'd9000) $display("FAIL beat_mag: got %0d want 9000", peak_mag); else passed++;
    step();
  endtask

  task automatic test_back_to_back();
    int ns;
    int scyc[2];
    int sfreq[2];
    int smag[2];
    ns = 0;
    scyc = '{0, 0}; sfreq = '{0, 0}; smag = '{0, 0};
    fork
      begin
        send_frame(4, 20000, -1, 0, 100, 0, 64, 1'b1);
        send_frame(12, 30000, -1, 0, 100, 0, 64, 1'b1);
      end
      begin
        for (int c = 0; c < 140; c++) begin
          step();
          if (freq_strobe) begin
            if (ns < 2) begin
              scyc[ns]  = c;
              sfreq[ns] = int'(freq_out);
              smag[ns]  = int'(peak_mag);
            end
            ns++;
          end
        end
      end
    join
    total++; if (ns !== 2) $display("FAIL b2b_count: got %0d want 2", ns); else passed++;
    total++; if (scyc[1] - scyc[0] !== 64) $display("FAIL b2b_gap: got %0d want 64", scyc[1] - scyc[0]); else passed++;
    total++; if (sfreq[0] !== 95) $display("FAIL b2b_freq0: got %0d want 95", sfreq[0]); else passed++;
    total++; if (sfreq[1] !== 286) $display("FAIL b2b_freq1: got %0d want 286", sfreq[1]); else passed++;
    total++; if (smag[0] !== 20000) $display("FAIL b2b_mag0: got %0d want 20000", smag[0]); else passed++;
    total++; if (smag[1] !== 30000) $display("FAIL b2b_mag1: got %0d want 30000", smag[1]); else passed++;
  endtask

  task automatic test_reset_mid_frame();
    send_frame(15, 50000, -1, 0, 100, 0, 20, 1'b0);
    reset_n = 1'b0;
    #1;
    total++; if (freq_out !== 27'd0) $display("FAIL mid_reset_freq: got %0d want 0", freq_out); else passed++;
    total++; if (freq_valid !== 1'b0) $display("FAIL mid_reset_valid: got %b want 0", freq_valid); else passed++;
    step(); step();
    reset_n = 1'b1;
    step();
    send_frame(3, 7000, -1, 0, 100, 0, 64, 1'b1);
    step(); step();
    total++; if (freq_strobe !== 1'b1) $display("FAIL mid_strobe: got %b want 1", freq_strobe); else passed++;
    total++; if (freq_out !== 27'd71) $display("FAIL mid_freq: got %0d want 71", freq_out); else passed++;
    total++; if (peak_mag !== 24'd7000) $display("FAIL mid_mag: got %0d want 7000", peak_mag); else passed++;
    step();
  endtask

  initial begin
    test_reset();
    test_single_peak();
    test_tie();
    test_below_thresh();
    test_thresh_edge();
    test_window();
    test_empty_window();
    test_single_beat();
    test_back_to_back();
    test_reset_mid_frame();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
